// File: rtl/ccd_frame_capture.sv
// CCD front-end capture: registers the raw pixel stream, gates whole frames under
// start/end control, and tracks pixel coordinates, frame count and geometry errors.
module ccd_frame_capture #(
  parameter int unsigned COLUMN_WIDTH = 800,
  parameter int unsigned FRAME_ROWS   = 480,
  parameter int unsigned DATA_W       = 12
) (
  input  logic              CCD_PIXCLK,
  input  logic              iRst_n,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iStart,
  input  logic              iEnd,
  output logic [DATA_W-1:0] oDATA,
  output logic [15:0]       oX_Cont,
  output logic [15:0]       oY_Cont,
  output logic              oFval,
  output logic              oDVAL,
  output logic [31:0]       oFrame_Cont,
  output logic              oFrameErr,
  output logic              oBusy
);

  localparam logic [15:0] X_LAST   = 16'(COLUMN_WIDTH - 1);
  localparam logic [15:0] Y_EXPECT = 16'(FRAME_ROWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] r_data;
  logic              r_fval;
  logic              r_lval;
  logic              r_fval_d;
  logic              f_rise;
  logic              f_fall;
  logic              m_fval;
  logic              m_fval_d;
  logic              pix_valid;
  logic              frame_end;
  logic [15:0]       x_cnt;
  logic [15:0]       y_cnt;

  always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      r_data   <= '0;
      r_fval   <= 1'b0;
      r_lval   <= 1'b0;
      r_fval_d <= 1'b0;
    end else begin
      r_data   <= iDATA;
      r_fval   <= iFVAL;
      r_lval   <= iLVAL;
      r_fval_d <= r_fval;
    end
  end

  assign f_rise = r_fval & ~r_fval_d;
  assign f_fall = ~r_fval & r_fval_d;

  always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_next;
  end

  // A frame already under way when armed never sees f_rise, so it is skipped whole;
  // on the rising edge itself the gate opens combinationally so pixel 0 is kept.
  always_comb begin
    state_next = state;
    m_fval     = 1'b0;
    unique case (state)
      IDLE: begin
        if (iStart && !iEnd) state_next = ARMED;
      end
      ARMED: begin
        m_fval = r_fval & f_rise;
        if (f_rise)    state_next = CAPTURE;
        else if (iEnd) state_next = IDLE;
      end
      CAPTURE: begin
        m_fval = r_fval;
        if (iEnd && f_fall) state_next = IDLE;
        else if (iEnd)      state_next = DRAIN;
      end
      DRAIN: begin
        m_fval = r_fval;
        if (f_fall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pix_valid = m_fval & r_lval;
  assign frame_end = m_fval_d & ~m_fval;
  assign oBusy     = (state != IDLE);

  // Counters run continuously across lines of a frame; over-long lines wrap X early.
  always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (!m_fval) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (r_lval) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 16'd1;
      end else begin
        x_cnt <= x_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      oDATA       <= '0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFval       <= 1'b0;
      oDVAL       <= 1'b0;
      oFrame_Cont <= '0;
      oFrameErr   <= 1'b0;
      m_fval_d    <= 1'b0;
    end else begin
      oFval    <= m_fval;
      oDVAL    <= pix_valid;
      m_fval_d <= m_fval;
      if (pix_valid) begin
        oDATA   <= r_data;
        oX_Cont <= x_cnt;
        oY_Cont <= y_cnt;
      end
      if (frame_end) oFrame_Cont <= oFrame_Cont + 32'd1;
      oFrameErr <= frame_end & ((y_cnt != Y_EXPECT) | (x_cnt != '0));
    end
  end

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Bench for ccd_frame_capture: random pixel frames, expected pixels/coordinates
// derived from each frame's pixel index (x = k mod W, y = k div W).
module tb_ccd_frame_capture;

  localparam int W    = 20;
  localparam int ROWS = 12;

  logic        CCD_PIXCLK = 1'b0;
  logic        iRst_n;
  logic [11:0] iDATA;
  logic        iFVAL, iLVAL, iStart, iEnd;
  logic [11:0] oDATA;
  logic [15:0] oX_Cont, oY_Cont;
  logic        oFval, oDVAL;
  logic [31:0] oFrame_Cont;
  logic        oFrameErr, oBusy;

  ccd_frame_capture #(
    .COLUMN_WIDTH(W),
    .FRAME_ROWS  (ROWS),
    .DATA_W      (12)
  ) dut (
    .CCD_PIXCLK (CCD_PIXCLK),
    .iRst_n     (iRst_n),
    .iDATA      (iDATA),
    .iFVAL      (iFVAL),
    .iLVAL      (iLVAL),
    .iStart     (iStart),
    .iEnd       (iEnd),
    .oDATA      (oDATA),
    .oX_Cont    (oX_Cont),
    .oY_Cont    (oY_Cont),
    .oFval      (oFval),
    .oDVAL      (oDVAL),
    .oFrame_Cont(oFrame_Cont),
    .oFrameErr  (oFrameErr),
    .oBusy      (oBusy)
  );

  always #5 CCD_PIXCLK = ~CCD_PIXCLK;

  typedef struct {
    logic [11:0] d;
    logic [15:0] x;
    logic [15:0] y;
    int          c;
  } pix_t;

  pix_t obs_q[$];
  pix_t exp_q[$];
  int   cyc        = 0;
  int   err_cycles = 0;
  int   exp_frames = 0;
  int   exp_errs   = 0;
  int   errors     = 0;
  int   checks     = 0;

  always @(posedge CCD_PIXCLK) cyc <= cyc + 1;

  always @(negedge CCD_PIXCLK) begin
    if (oDVAL === 1'b1) obs_q.push_back('{oDATA, oX_Cont, oY_Cont, cyc});
    if (oFrameErr === 1'b1) err_cycles = err_cycles + 1;
  end

  task automatic tick;
    @(posedge CCD_PIXCLK);
    #1;
  endtask

  function automatic int first_mismatch(input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= obs_q.size()) return i;
      if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].x !== exp_q[i].x ||
          obs_q[base+i].y !== exp_q[i].y || obs_q[base+i].c !== exp_q[i].c) return i;
    end
    return -1;
  endfunction

  function automatic pix_t obs_at(input int i);
    pix_t p;
    p = '{12'h0, 16'h0, 16'h0, 0};
    if (i < obs_q.size()) p = obs_q[i];
    return p;
  endfunction

  // Drives one frame; a captured frame's pixels appear two clocks after being driven.
  task automatic send_frame(input int rows, input int long_row, input int start_row,
                            input int end_row, input bit capture);
    int k;
    int len;
    k = 0;
    iFVAL = 1'b1;
    iLVAL = 1'b0;
    repeat (2 + $urandom_range(0, 2)) tick();
    for (int r = 0; r < rows; r++) begin
      len = (r == long_row) ? W + 2 : W;
      for (int i = 0; i < len; i++) begin
        iStart = (i == 0 && r == start_row);
        iEnd   = (i == 0 && r == end_row);
        iLVAL  = 1'b1;
        iDATA  = 12'($urandom);
        if (capture) exp_q.push_back('{iDATA, 16'(k % W), 16'(k / W), cyc + 2});
        k++;
        tick();
      end
      iStart = 1'b0;
      iEnd   = 1'b0;
      iLVAL  = 1'b0;
      repeat (2 + $urandom_range(0, 3)) tick();
    end
    iFVAL = 1'b0;
    repeat (6 + $urandom_range(0, 3)) tick();
    if (capture) begin
      exp_frames++;
      if ((k % W) != 0 || (k / W) != ROWS) exp_errs++;
    end
  endtask

  task automatic test_reset;
    int base;
    iRst_n = 1'b0; iDATA = '0; iFVAL = 1'b0; iLVAL = 1'b0; iStart = 1'b0; iEnd = 1'b0;
    repeat (3) tick();
    checks++;
    if ({oDATA, oX_Cont, oY_Cont, oFval, oDVAL, oFrame_Cont, oFrameErr, oBusy} !== '0) begin
      errors++;
      $display("FAIL reset_state: dvals=%b busy=%b frames=%0d x=%0d y=%0d, expected all 0",
               oDVAL, oBusy, oFrame_Cont, oX_Cont, oY_Cont);
    end
    iRst_n = 1'b1;
    tick();
    iStart = 1'b1; tick(); iStart = 1'b0;
    iFVAL = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < W + 8; i++) begin
      iLVAL = (i < W || i >= W + 3);
      iDATA = 12'($urandom);
      tick();
    end
    checks++;
    if ({oDVAL, oBusy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_premid: dval,busy=%b, expected 11", {oDVAL, oBusy});
    end
    #2 iRst_n = 1'b0;
    #1;
    checks++;
    if ({oDATA, oX_Cont, oY_Cont, oFval, oDVAL, oFrame_Cont, oFrameErr, oBusy} !== '0) begin
      errors++;
      $display("FAIL reset_async: dval=%b fval=%b busy=%b x=%0d y=%0d data=%h, expected all 0",
               oDVAL, oFval, oBusy, oX_Cont, oY_Cont, oDATA);
    end
    iFVAL = 1'b0; iLVAL = 1'b0;
    repeat (2) tick();
    iRst_n = 1'b1;
    tick();
    base = obs_q.size();
    send_frame(ROWS, -1, -1, -1, 1'b0);
    checks++;
    if (obs_q.size() !== base || oFrame_Cont !== 32'd0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start: pixels=%0d frames=%0d busy=%b, expected 0 0 0",
               obs_q.size() - base, oFrame_Cont, oBusy);
    end
  endtask

  task automatic test_full_frame;
    int base, mm;
    pix_t o;
    exp_q.delete();
    base = obs_q.size();
    iStart = 1'b1; tick(); iStart = 1'b0; tick();
    checks++;
    if (oBusy !== 1'b1) begin
      errors++; $display("FAIL full_armed_busy: busy=%b, expected 1", oBusy);
    end
    send_frame(ROWS, -1, -1, -1, 1'b1);
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL full_count: pixels=%0d, expected %0d", obs_q.size() - base, exp_q.size());
    end
    checks++;
    mm = first_mismatch(base);
    if (mm != -1) begin
      errors++; o = obs_at(base + mm);
      $display("FAIL full_pixels: #%0d got d=%h x=%0d y=%0d cyc=%0d, expected d=%h x=%0d y=%0d cyc=%0d",
               mm, o.d, o.x, o.y, o.c, exp_q[mm].d, exp_q[mm].x, exp_q[mm].y, exp_q[mm].c);
    end
    checks++;
    if (oFrame_Cont !== 32'(exp_frames) || err_cycles !== exp_errs) begin
      errors++;
      $display("FAIL full_frames: frames=%0d errcycles=%0d, expected %0d %0d",
               oFrame_Cont, err_cycles, exp_frames, exp_errs);
    end
  endtask

  task automatic test_stop;
    int base, mm;
    pix_t o;
    exp_q.delete();
    base = obs_q.size();
    send_frame(ROWS, -1, -1, 6, 1'b1);
    send_frame(ROWS, -1, -1, -1, 1'b0);
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL stop_count: pixels=%0d, expected %0d", obs_q.size() - base, exp_q.size());
    end
    checks++;
    mm = first_mismatch(base);
    if (mm != -1) begin
      errors++; o = obs_at(base + mm);
      $display("FAIL stop_pixels: #%0d got d=%h x=%0d y=%0d cyc=%0d, expected d=%h x=%0d y=%0d cyc=%0d",
               mm, o.d, o.x, o.y, o.c, exp_q[mm].d, exp_q[mm].x, exp_q[mm].y, exp_q[mm].c);
    end
    checks++;
    if (oFrame_Cont !== 32'(exp_frames) || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL stop_state: frames=%0d busy=%b, expected %0d 0", oFrame_Cont, oBusy, exp_frames);
    end
  endtask

  task automatic test_arm_mid_frame;
    int base, mm;
    pix_t o;
    exp_q.delete();
    base = obs_q.size();
    send_frame(ROWS, -1, 3, -1, 1'b0);
    send_frame(ROWS, -1, -1, -1, 1'b1);
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL armmid_count: pixels=%0d, expected %0d", obs_q.size() - base, exp_q.size());
    end
    checks++;
    mm = first_mismatch(base);
    if (mm != -1) begin
      errors++; o = obs_at(base + mm);
      $display("FAIL armmid_pixels: #%0d got d=%h x=%0d y=%0d cyc=%0d, expected d=%h x=%0d y=%0d cyc=%0d",
               mm, o.d, o.x, o.y, o.c, exp_q[mm].d, exp_q[mm].x, exp_q[mm].y, exp_q[mm].c);
    end
    checks++;
    if (oFrame_Cont !== 32'(exp_frames) || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL armmid_state: frames=%0d busy=%b, expected %0d 1", oFrame_Cont, oBusy, exp_frames);
    end
  endtask

  task automatic test_short_frame;
    int base, mm;
    pix_t o;
    exp_q.delete();
    base = obs_q.size();
    send_frame(3, -1, -1, -1, 1'b1);
    checks++;
    mm = first_mismatch(base);
    if (mm != -1 || obs_q.size() - base !== exp_q.size()) begin
      errors++; o = obs_at(base + mm);
      $display("FAIL short_pixels: #%0d got d=%h x=%0d y=%0d (n=%0d), expected d=%h x=%0d y=%0d (n=%0d)",
               mm, o.d, o.x, o.y, obs_q.size() - base, exp_q[0].d, exp_q[0].x, exp_q[0].y, exp_q.size());
    end
    checks++;
    if (oFrame_Cont !== 32'(exp_frames) || err_cycles !== exp_errs) begin
      errors++;
      $display("FAIL short_err: frames=%0d errcycles=%0d, expected %0d %0d",
               oFrame_Cont, err_cycles, exp_frames, exp_errs);
    end
  endtask

  task automatic test_back_to_back;
    int base, mm;
    pix_t o;
    exp_q.delete();
    base = obs_q.size();
    for (int f = 0; f < 3; f++) send_frame(ROWS - 1 + $urandom_range(0, 2), -1, -1, -1, 1'b1);
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: pixels=%0d, expected %0d", obs_q.size() - base, exp_q.size());
    end
    checks++;
    mm = first_mismatch(base);
    if (mm != -1) begin
      errors++; o = obs_at(base + mm);
      $display("FAIL b2b_pixels: #%0d got d=%h x=%0d y=%0d cyc=%0d, expected d=%h x=%0d y=%0d cyc=%0d",
               mm, o.d, o.x, o.y, o.c, exp_q[mm].d, exp_q[mm].x, exp_q[mm].y, exp_q[mm].c);
    end
    checks++;
    if (oFrame_Cont !== 32'(exp_frames) || err_cycles !== exp_errs) begin
      errors++;
      $display("FAIL b2b_frames: frames=%0d errcycles=%0d, expected %0d %0d",
               oFrame_Cont, err_cycles, exp_frames, exp_errs);
    end
  endtask

  task automatic test_long_line;
    int base, mm;
    pix_t o;
    exp_q.delete();
    base = obs_q.size();
    send_frame(ROWS, 2, -1, 4, 1'b1);
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL long_count: pixels=%0d, expected %0d", obs_q.size() - base, exp_q.size());
    end
    checks++;
    mm = first_mismatch(base);
    if (mm != -1) begin
      errors++; o = obs_at(base + mm);
      $display("FAIL long_pixels: #%0d got d=%h x=%0d y=%0d cyc=%0d, expected d=%h x=%0d y=%0d cyc=%0d",
               mm, o.d, o.x, o.y, o.c, exp_q[mm].d, exp_q[mm].x, exp_q[mm].y, exp_q[mm].c);
    end
    checks++;
    if (oFrame_Cont !== 32'(exp_frames) || err_cycles !== exp_errs || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL long_err: frames=%0d errcycles=%0d busy=%b, expected %0d %0d 0",
               oFrame_Cont, err_cycles, oBusy, exp_frames, exp_errs);
    end
    iStart = 1'b1; iEnd = 1'b1; tick(); iStart = 1'b0; iEnd = 1'b0; tick();
    checks++;
    if (oBusy !== 1'b0) begin
      errors++; $display("FAIL start_end_idle: busy=%b, expected 0", oBusy);
    end
    base = obs_q.size();
    send_frame(ROWS, -1, -1, -1, 1'b0);
    checks++;
    if (obs_q.size() !== base || oFrame_Cont !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL start_end_nocap: pixels=%0d frames=%0d, expected 0 %0d",
               obs_q.size() - base, oFrame_Cont, exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stop();
    test_arm_mid_frame();
    test_short_frame();
    test_back_to_back();
    test_long_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
